// File: rtl/regfile_ctrl_pkg.sv
// Shared sizing and types for the register-file writeback controller.
package regfile_ctrl_pkg;
  localparam int DATA_W     = 16;
  localparam int NUM_REGS   = 8;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t         dr;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the pointer only moves when both requesters contend.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic rr_ptr_q;
  logic rr_ptr_d;

  // A lone requester wins outright; under contention the pointer picks and then flips.
  always_comb begin
    gnt      = req;
    rr_ptr_d = rr_ptr_q;
    if (req == 2'b11) begin
      gnt      = rr_ptr_q ? 2'b10 : 2'b01;
      rr_ptr_d = ~rr_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the register file write port and
// tracks pending destinations in a busy scoreboard for decode.
module regfile_wb_arbiter #(
  parameter  int DATA_W   = regfile_ctrl_pkg::DATA_W,
  parameter  int NUM_REGS = regfile_ctrl_pkg::NUM_REGS,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   rsv_valid,
  input  logic [AW-1:0]          rsv_dr,
  output logic                   rsv_ready,
  input  logic [1:0]             wb_valid,
  input  logic [1:0][AW-1:0]     wb_dr,
  input  logic [1:0][DATA_W-1:0] wb_data,
  output logic [1:0]             wb_ready,
  output logic                   rf_load,
  output logic [AW-1:0]          rf_dr,
  output logic [DATA_W-1:0]      rf_din,
  output logic [NUM_REGS-1:0]    busy,
  output logic                   wb_error
);
  logic [1:0]          gnt;
  logic                gnt_idx;
  logic [NUM_REGS-1:0] busy_q,     busy_d;
  logic                rf_load_q,  rf_load_d;
  logic [AW-1:0]       rf_dr_q,    rf_dr_d;
  logic [DATA_W-1:0]   rf_din_q,   rf_din_d;
  logic                wb_error_q, wb_error_d;

  rr_arbiter2 u_arb (
    .clk (Clk),
    .rst (Reset),
    .req (wb_valid),
    .gnt (gnt)
  );

  assign gnt_idx   = gnt[1];
  assign wb_ready  = gnt;
  assign rsv_ready = !busy_q[rsv_dr];

  always_comb begin
    busy_d     = busy_q;
    rf_load_d  = |gnt;
    rf_dr_d    = rf_dr_q;
    rf_din_d   = rf_din_q;
    wb_error_d = wb_error_q;
    // Clear first so a fresh reservation of a just-written register survives.
    if (rf_load_q) begin
      busy_d[rf_dr_q] = 1'b0;
    end
    if (rsv_valid && rsv_ready) begin
      busy_d[rsv_dr] = 1'b1;
    end
    if (|gnt) begin
      rf_dr_d  = wb_dr[gnt_idx];
      rf_din_d = wb_data[gnt_idx];
      if (!busy_q[wb_dr[gnt_idx]]) begin
        wb_error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      busy_q     <= '0;
      rf_load_q  <= 1'b0;
      rf_dr_q    <= '0;
      rf_din_q   <= '0;
      wb_error_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      rf_load_q  <= rf_load_d;
      rf_dr_q    <= rf_dr_d;
      rf_din_q   <= rf_din_d;
      wb_error_q <= wb_error_d;
    end
  end

  assign busy     = busy_q;
  assign rf_load  = rf_load_q;
  assign rf_dr    = rf_dr_q;
  assign rf_din   = rf_din_q;
  assign wb_error = wb_error_q;
endmodule
